// File: rtl/sd_dat_write.sv
// SD DAT-line block transmitter: serialises a 32-bit word stream onto 1 or 4 lanes with per-lane CRC16.
// Optional SD_DAT_WRITE_CLK_STOP_EN: stall with clk_stop_o on refill underrun instead of zero-filling.
module sd_dat_write #(
  parameter int NumLanes      = 4,
  parameter int MaxBlockBytes = 512,
  parameter int BlkSizeWidth  = 12
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clk_en_p_i,
  input  logic                    clk_en_n_i,
  input  logic                    div_1_i,
  input  logic                    wide_bus_i,
  input  logic [BlkSizeWidth-1:0] block_size_i,
  input  logic                    start_tx_i,
  input  logic [31:0]             data_i,
  input  logic                    data_valid_i,
  output logic                    data_ready_o,
`ifdef SD_DAT_WRITE_CLK_STOP_EN
  output logic                    clk_stop_o,
`endif
  output logic [NumLanes-1:0]     dat_o,
  output logic [NumLanes-1:0]     dat_en_o,
  output logic                    tx_done_o,
  output logic                    underrun_o
);

  localparam int WordCntW = $clog2(MaxBlockBytes / 4 + 1);

  localparam logic [2:0] StReady = 3'd0;
  localparam logic [2:0] StLoad  = 3'd1;
  localparam logic [2:0] StStart = 3'd2;
  localparam logic [2:0] StData  = 3'd3;
  localparam logic [2:0] StCrc   = 3'd4;
  localparam logic [2:0] StEnd   = 3'd5;

  // Handshake: a word is taken on a clk_i rising edge where data_ready_o and data_valid_i are both high.

  logic [2:0]              state_q;
  logic                    wide_q;
  logic [WordCntW-1:0]     word_left_q;
  logic [4:0]              bit_cnt_q;
  logic [3:0]              crc_cnt_q;
  logic [31:0]             sr_q;
  logic [15:0]             crc_q    [NumLanes];
  logic [15:0]             crc_next [NumLanes];
  logic                    underrun_q;
  logic [NumLanes-1:0]     active, lane_bit, crc_msb, line_dat, line_en;
  logic [NumLanes-1:0]     p_dat_q, p_en_q, n_dat_q, n_en_q;
  logic [BlkSizeWidth-3:0] words_in;
  logic [31:0]             word_in;
  logic                    last_bit, refill;
  logic                    unused_size_bits;

  assign unused_size_bits = ^block_size_i[1:0];
  assign words_in = block_size_i[BlkSizeWidth-1:2];
  // Byte 0 lands in the top of the shift register so both modes just shift left.
  assign word_in  = {data_i[7:0], data_i[15:8], data_i[23:16], data_i[31:24]};
  assign last_bit = bit_cnt_q == (wide_q ? 5'd7 : 5'd31);
  assign refill   = (state_q == StData) && last_bit && (word_left_q != '0);

`ifdef SD_DAT_WRITE_CLK_STOP_EN
  logic stall_q;
  assign clk_stop_o   = stall_q;
  assign data_ready_o = stall_q | (clk_en_p_i & ((state_q == StLoad) | refill));
`else
  assign data_ready_o = clk_en_p_i & ((state_q == StLoad) | refill);
`endif

  assign tx_done_o  = state_q == StReady;
  assign underrun_o = underrun_q;

  always_comb begin
    active   = '0;
    lane_bit = '0;
    crc_msb  = '0;
    for (int i = 0; i < NumLanes; i++) begin
      active[i]   = (i == 0) || wide_q;
      lane_bit[i] = wide_q ? sr_q[28+i] : sr_q[31];
      crc_msb[i]  = crc_q[i][15];
      crc_next[i] = crc_q[i];
      if (active[i]) begin
        crc_next[i] = {crc_q[i][14:0], 1'b0} ^
                      ((lane_bit[i] ^ crc_q[i][15]) ? 16'h1021 : 16'h0000);
      end
    end
  end

  always_comb begin
    line_dat = '1;
    line_en  = '0;
    case (state_q)
      StStart: begin line_dat = ~active;             line_en = active; end
      StData:  begin line_dat = lane_bit | ~active;  line_en = active; end
      StCrc:   begin line_dat = crc_msb | ~active;   line_en = active; end
      StEnd:   begin line_dat = '1;                  line_en = active; end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StReady;
      wide_q      <= 1'b0;
      word_left_q <= '0;
      bit_cnt_q   <= '0;
      crc_cnt_q   <= '0;
      sr_q        <= '0;
      underrun_q  <= 1'b0;
      for (int i = 0; i < NumLanes; i++) crc_q[i] <= '0;
`ifdef SD_DAT_WRITE_CLK_STOP_EN
      stall_q     <= 1'b0;
`endif
    end else begin
`ifdef SD_DAT_WRITE_CLK_STOP_EN
      // While stalled the SD clock is stopped, so the word is taken on any clk_i edge.
      if (stall_q) begin
        if (data_valid_i) begin
          stall_q     <= 1'b0;
          crc_q       <= crc_next;
          sr_q        <= word_in;
          bit_cnt_q   <= '0;
          word_left_q <= word_left_q - WordCntW'(1);
        end
      end else
`endif
      if (clk_en_p_i) begin
        case (state_q)
          StReady: begin
            if (start_tx_i && (words_in != '0)) begin
              state_q     <= StLoad;
              wide_q      <= (NumLanes == 4) && wide_bus_i;
              word_left_q <= WordCntW'(words_in - (BlkSizeWidth-2)'(1));
              underrun_q  <= 1'b0;
            end
          end
          StLoad: begin
            for (int i = 0; i < NumLanes; i++) crc_q[i] <= '0;
            if (data_valid_i) begin
              sr_q    <= word_in;
              state_q <= StStart;
            end
          end
          StStart: begin
            state_q   <= StData;
            bit_cnt_q <= '0;
          end
          StData: begin
            if (!last_bit) begin
              crc_q     <= crc_next;
              bit_cnt_q <= bit_cnt_q + 5'd1;
              sr_q      <= wide_q ? {sr_q[27:0], 4'h0} : {sr_q[30:0], 1'b0};
            end else if (word_left_q == '0) begin
              crc_q     <= crc_next;
              crc_cnt_q <= '0;
              state_q   <= StCrc;
            end else if (data_valid_i) begin
              crc_q       <= crc_next;
              sr_q        <= word_in;
              bit_cnt_q   <= '0;
              word_left_q <= word_left_q - WordCntW'(1);
            end else begin
`ifdef SD_DAT_WRITE_CLK_STOP_EN
              stall_q     <= 1'b1;
`else
              crc_q       <= crc_next;
              sr_q        <= '0;
              bit_cnt_q   <= '0;
              word_left_q <= word_left_q - WordCntW'(1);
              underrun_q  <= 1'b1;
`endif
            end
          end
          StCrc: begin
            for (int i = 0; i < NumLanes; i++) crc_q[i] <= {crc_q[i][14:0], 1'b0};
            crc_cnt_q <= crc_cnt_q + 4'd1;
            if (crc_cnt_q == 4'd15) state_q <= StEnd;
          end
          StEnd:   state_q <= StReady;
          default: state_q <= StReady;
        endcase
      end
    end
  end

  // Half-SD-cycle launch offset: falling SD edge, or falling clk_i edge when SD clock == clk_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      p_dat_q <= '1;
      p_en_q  <= '0;
    end else if (clk_en_n_i) begin
      p_dat_q <= line_dat;
      p_en_q  <= line_en;
    end
  end

  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      n_dat_q <= '1;
      n_en_q  <= '0;
    end else begin
      n_dat_q <= line_dat;
      n_en_q  <= line_en;
    end
  end

  assign dat_o    = div_1_i ? n_dat_q : p_dat_q;
  assign dat_en_o = div_1_i ? n_en_q  : p_en_q;

endmodule

// File: tb/tb_sd_dat_write.sv
// Scoreboard bench for sd_dat_write: a byte/nibble-level model predicts every line symbol of a block.
module tb_sd_dat_write;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        clk_en_p_i, clk_en_n_i, div_1_i, wide_bus_i;
  logic [11:0] block_size_i;
  logic        start_tx_i;
  logic [31:0] data_i;
  logic        data_valid_i;
  logic        data_ready_o;
  logic [3:0]  dat_o, dat_en_o;
  logic        tx_done_o, underrun_o;

  int checks = 0;
  int errors = 0;
  logic [7:0]  exp_q[$];      // {enable[3:0], dat[3:0]} per SD cycle
  logic [31:0] cur_words[$];
  logic [31:0] feed_q[$];
  int          fed = 0;
  int          drop_at = -1;
  int          pe_changes = 0;

  sd_dat_write dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clk_en_p_i(clk_en_p_i), .clk_en_n_i(clk_en_n_i),
    .div_1_i(div_1_i), .wide_bus_i(wide_bus_i), .block_size_i(block_size_i),
    .start_tx_i(start_tx_i), .data_i(data_i), .data_valid_i(data_valid_i),
    .data_ready_o(data_ready_o), .dat_o(dat_o), .dat_en_o(dat_en_o),
    .tx_done_o(tx_done_o), .underrun_o(underrun_o)
  );

  // clock / reset block
  always #5 clk_i = ~clk_i;

  initial begin
    #900_000;
    errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // SD clock enables: divide-by-2, or rising enable tied high in div-1 mode
  initial begin
    bit ph;
    ph = 1'b0;
    clk_en_p_i = 1'b0;
    clk_en_n_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (div_1_i) begin
        clk_en_p_i = 1'b1;
        clk_en_n_i = 1'b0;
      end else begin
        ph = ~ph;
        clk_en_p_i = ph;
        clk_en_n_i = ~ph;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((b ^ c[15]) ? 16'h1021 : 16'h0000);
  endfunction

  // reference model: enumerate bytes, then bits or nibbles, then CRC and framing
  task automatic push_expected(input bit wide, input int nwords);
    logic [3:0]  mask, d;
    logic [3:0]  cyc[$];
    logic [15:0] crc[4];
    logic [31:0] w;
    logic [7:0]  b;
    mask = wide ? 4'hF : 4'h1;
    for (int k = 0; k < nwords; k++) begin
      w = (k == drop_at) ? 32'h0 : cur_words[k];
      for (int by = 0; by < 4; by++) begin
        b = w[8*by +: 8];
        if (wide) begin
          cyc.push_back(b[7:4]);
          cyc.push_back(b[3:0]);
        end else begin
          for (int j = 7; j >= 0; j--) cyc.push_back({3'b111, b[j]});
        end
      end
    end
    for (int i = 0; i < 4; i++) crc[i] = 16'h0;
    foreach (cyc[c]) begin
      d = cyc[c];
      for (int i = 0; i < 4; i++) if (mask[i]) crc[i] = crc_step(crc[i], d[i]);
    end
    exp_q.push_back({mask, ~mask});
    foreach (cyc[c]) exp_q.push_back({mask, cyc[c]});
    for (int j = 15; j >= 0; j--) begin
      d = 4'hF;
      for (int i = 0; i < 4; i++) if (mask[i]) d[i] = crc[i][j];
      exp_q.push_back({mask, d});
    end
    exp_q.push_back({mask, 4'hF});
  endtask

  // word driver: offers the head of feed_q; a dropped word is consumed with valid low
  initial begin
    data_i = '0;
    data_valid_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (feed_q.size() > 0) begin
        data_i = feed_q[0];
        data_valid_i = (fed != drop_at);
      end else begin
        data_i = $urandom();
        data_valid_i = 1'b0;
      end
      #4;
      if (data_ready_o && feed_q.size() > 0 && (data_valid_i || fed == drop_at)) begin
        void'(feed_q.pop_front());
        fed++;
      end
    end
  end

  // monitor: one sample per SD cycle, compared whenever any lane is enabled
  initial begin
    logic [7:0] pre, got, e;
    bit s;
    forever begin
      @(negedge clk_i);
      #4;
      pre = {dat_en_o, dat_o};
      @(posedge clk_i);
      s = div_1_i || clk_en_n_i;
      #2;
      got = {dat_en_o, dat_o};
      if (div_1_i && rst_ni && got !== pre) pe_changes++;
      if (s && dat_en_o != 4'h0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_symbol", {24'h0, got}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("line", {24'h0, got}, {24'h0, e});
        end
      end
    end
  end

  task automatic run_block(input bit wide, input int bsize, input int drop);
    int n, limit, nwords;
    nwords = bsize >> 2;
    drop_at = drop;
    push_expected(wide, nwords);
    fed = 0;
    feed_q = cur_words;
    @(negedge clk_i);
    wide_bus_i = wide;
    block_size_i = 12'(bsize);
    start_tx_i = 1'b1;
    n = 0;
    while (tx_done_o && n < 40) begin @(negedge clk_i); n++; end
    check("start_accept", {31'h0, tx_done_o}, 32'h0);
    // mode inputs and a held start must be ignored while busy
    wide_bus_i = ~wide;
    block_size_i = 12'($urandom());
    repeat (3) @(negedge clk_i);
    start_tx_i = 1'b0;
    limit = (nwords * 32 + 40) * 2 + 100;
    n = 0;
    while (!tx_done_o && n < limit) begin @(negedge clk_i); n++; end
    check("block_done", {31'h0, tx_done_o}, 32'h1);
    repeat (6) @(negedge clk_i);
    check("symbols_left", exp_q.size(), 32'h0);
    check("idle_dat", {28'h0, dat_o}, 32'hF);
    check("idle_en", {28'h0, dat_en_o}, 32'h0);
    exp_q.delete();
    feed_q.delete();
    drop_at = -1;
  endtask

  task automatic rand_words(input int n);
    cur_words.delete();
    repeat (n) cur_words.push_back($urandom());
  endtask

  task automatic const_words(input int n, input logic [31:0] v);
    cur_words.delete();
    repeat (n) cur_words.push_back(v);
  endtask

  initial begin
    int sz, lowcnt;
    rst_ni = 1'b0;
    div_1_i = 1'b0;
    wide_bus_i = 1'b0;
    block_size_i = '0;
    start_tx_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_dat", {28'h0, dat_o}, 32'hF);
    check("rst_en", {28'h0, dat_en_o}, 32'h0);
    check("rst_done", {31'h0, tx_done_o}, 32'h1);
    check("rst_ready", {31'h0, data_ready_o}, 32'h0);
    check("rst_underrun", {31'h0, underrun_o}, 32'h0);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    const_words(1, 32'h0000_00A5);
    run_block(1'b0, 4, -1);
    run_block(1'b1, 4, -1);
    const_words(128, 32'hFFFF_FFFF);
    run_block(1'b0, 512, -1);
    check("no_underrun", {31'h0, underrun_o}, 32'h0);

    for (int t = 0; t < 4; t++) begin
      sz = 4 * $urandom_range(1, 24);
      rand_words(sz / 4);
      run_block(1'($urandom_range(0, 1)), sz + $urandom_range(0, 3), -1);
    end
    check("no_underrun_rand", {31'h0, underrun_o}, 32'h0);

    const_words(128, 32'h0);
    run_block(1'b1, 512, 9);
    check("underrun_set", {31'h0, underrun_o}, 32'h1);
    rand_words(8);
    run_block(1'b0, 32, 3);
    check("underrun_rand", {31'h0, underrun_o}, 32'h1);
    rand_words(2);
    run_block(1'b1, 8, -1);
    check("underrun_cleared", {31'h0, underrun_o}, 32'h0);

    // reset in the middle of DATA_OUT
    rand_words(16);
    drop_at = -1;
    fed = 0;
    push_expected(1'b0, 16);
    feed_q = cur_words;
    @(negedge clk_i);
    wide_bus_i = 1'b0;
    block_size_i = 12'd64;
    start_tx_i = 1'b1;
    repeat (4) @(negedge clk_i);
    start_tx_i = 1'b0;
    repeat (100) @(negedge clk_i);
    check("mid_busy", {31'h0, tx_done_o}, 32'h0);
    rst_ni = 1'b0;
    #1;
    check("mid_rst_dat", {28'h0, dat_o}, 32'hF);
    check("mid_rst_en", {28'h0, dat_en_o}, 32'h0);
    check("mid_rst_done", {31'h0, tx_done_o}, 32'h1);
    exp_q.delete();
    feed_q.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    block_size_i = 12'd3;
    start_tx_i = 1'b1;
    lowcnt = 0;
    repeat (20) begin @(negedge clk_i); if (!tx_done_o) lowcnt++; end
    start_tx_i = 1'b0;
    check("bs3_ignored", lowcnt, 32'h0);

    // SD clock equal to clk_i
    @(negedge clk_i);
    div_1_i = 1'b1;
    repeat (3) @(negedge clk_i);
    pe_changes = 0;
    rand_words(16);
    run_block(1'b1, 64, -1);
    rand_words(4);
    run_block(1'b0, 16, -1);
    check("div1_posedge_changes", pe_changes, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
